// File: rtl/hist_stream_engine_if.sv
// hist_stream_engine_if
//   Bundles the sample input stream, the dump request and the readout
//   stream of the histogram engine.
//   master : sample source / readout sink (drives sample_*, dump_req, out_ready)
//   slave  : the engine (drives sample_ready, out_*, busy, overflow)
//   Parameters must match those of the attached hist_stream_engine.
interface hist_stream_engine_if #(
    parameter int DATA_W   = 16,
    parameter int BIN_BITS = 4,
    parameter int CNT_W    = 8
);
    logic [DATA_W-1:0]   sample_data;
    logic                sample_valid;
    logic                sample_ready;
    logic                dump_req;
    logic [CNT_W-1:0]    out_data;
    logic [BIN_BITS-1:0] out_bin;
    logic                out_valid;
    logic                out_last;
    logic                out_ready;
    logic                busy;
    logic                overflow;

    modport master (
        output sample_data, sample_valid, dump_req, out_ready,
        input  sample_ready, out_data, out_bin, out_valid, out_last, busy, overflow
    );

    modport slave (
        input  sample_data, sample_valid, dump_req, out_ready,
        output sample_ready, out_data, out_bin, out_valid, out_last, busy, overflow
    );
endinterface

// File: rtl/hist_stream_engine.sv
// hist_stream_engine
//   Histogram engine: counts samples into 2^BIN_BITS bins selected by the
//   top BIN_BITS bits of each sample, then streams every bin out on request
//   (valid/ready, back-pressurable), clearing each bin as it is read.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : hist_stream_engine_if.slave (sample stream, dump_req,
//             readout stream, busy, sticky overflow)
//   Build option:
//     HIST_SATURATE_EN defined   -> a full counter holds at max on increment
//     HIST_SATURATE_EN undefined -> a full counter wraps to 0
//     Either way the increment of a full counter sets the sticky overflow,
//     which clears on the final readout handshake unless set on that edge.
module hist_stream_engine #(
    parameter int DATA_W   = 16,
    parameter int BIN_BITS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hist_stream_engine_if.slave   bus
);
    localparam int                  NUM_BINS = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0] LAST_IDX = '1;

    typedef enum logic {ACCUM, DUMP} state_t;

    state_t                         state_q, state_d;
    logic [BIN_BITS-1:0]            rd_idx_q, rd_idx_d;
    logic [NUM_BINS-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_BINS-1:0]            ovf_hit;
    logic                           ovf_q;
    logic [BIN_BITS-1:0]            bin;
    logic                           accept, hs, last;
    logic                           ready, valid, busy;
    logic                           unused_low;

    assign bin        = bus.sample_data[DATA_W-1 -: BIN_BITS];
    assign unused_low = ^bus.sample_data;   // only the top bits select a bin

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        accept   = 1'b0;
        hs       = 1'b0;
        last     = 1'b0;
        ready    = 1'b0;
        valid    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ACCUM: begin
                ready  = 1'b1;
                // a sample arriving with dump_req is still counted this edge
                accept = bus.sample_valid;
                if (bus.dump_req) begin
                    state_d  = DUMP;
                    rd_idx_d = '0;
                end
            end
            DUMP: begin
                valid = 1'b1;
                busy  = 1'b1;
                last  = (rd_idx_q == LAST_IDX);
                hs    = bus.out_ready;
                if (hs) begin
                    rd_idx_d = rd_idx_q + 1'b1;   // wraps to 0 after the last bin
                    if (last) state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // ---------------- per-bin counters ----------------
    // Increment (ACCUM) and clear (DUMP handshake) never coincide, as they
    // are decoded from different states.
    for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
        logic [CNT_W-1:0] cnt;
        logic             inc, clr, at_max;

        assign inc        = accept && (bin == BIN_BITS'(i));
        assign clr        = hs && (rd_idx_q == BIN_BITS'(i));
        assign at_max     = &cnt;
        assign ovf_hit[i] = inc && at_max;
        assign cnt_q[i]   = cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (clr) begin
                cnt <= '0;
            end else if (inc) begin
`ifdef HIST_SATURATE_EN
                if (!at_max) cnt <= cnt + 1'b1;
`else
                cnt <= cnt + 1'b1;
`endif
            end
        end
    end

    // Sticky overflow; a new overflow on the final handshake edge wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ovf_q <= 1'b0;
        else if (|ovf_hit)   ovf_q <= 1'b1;
        else if (hs && last) ovf_q <= 1'b0;
    end

    // ---------------- outputs ----------------
    assign bus.sample_ready = ready;
    assign bus.out_valid    = valid;
    assign bus.busy         = busy;
    assign bus.out_last     = last;
    assign bus.out_bin      = rd_idx_q;   // 0 whenever idle
    assign bus.out_data     = valid ? cnt_q[rd_idx_q] : '0;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_hist_stream_engine.sv
module tb_hist_stream_engine;
    localparam int DATA_W = 8, BIN_BITS = 3, CNT_W = 4;

    typedef struct {
        logic [2:0] bin;
        logic [3:0] data;
        logic       last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [3:0] model_cnt [8];
    logic       model_ovf;

    hist_stream_engine_if #(.DATA_W(DATA_W), .BIN_BITS(BIN_BITS), .CNT_W(CNT_W)) bus();

    hist_stream_engine #(.DATA_W(DATA_W), .BIN_BITS(BIN_BITS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 8; b++) model_cnt[b] = '0;
        model_ovf = 1'b0;
    endtask

    // One sample for one cycle, optionally with dump_req in the same cycle.
    task automatic send(input logic [7:0] d, input bit with_dump);
        logic [2:0] b;
        bus.sample_data  = d;
        bus.sample_valid = 1'b1;
        bus.dump_req     = with_dump;
        @(negedge clk);
        chk("sample_ready", bus.sample_ready, 1);
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        bus.dump_req     = 1'b0;
        b = d[7:5];
        if (model_cnt[b] == 4'hF) begin
            model_ovf = 1'b1;
`ifdef HIST_SATURATE_EN
            model_cnt[b] = 4'hF;
`else
            model_cnt[b] = 4'h0;
`endif
        end else begin
            model_cnt[b] = model_cnt[b] + 4'h1;
        end
    endtask

    // Readout of all bins. stall: out_ready pattern 1,0,0,1 repeated.
    // inject: drive samples throughout (must be refused and not counted).
    // abort_at: pulse reset when that many words have been taken (-1 = never).
    task automatic do_dump(input bit issue, input bit stall, input bit inject, input int abort_at);
        int   n   = 0;
        int   cyc = 0;
        int   ph  = 0;
        exp_t e;
        if (issue) begin
            bus.dump_req = 1'b1;
            @(posedge clk); #1;
            bus.dump_req = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
            e.bin  = 3'(b);
            e.data = model_cnt[b];
            e.last = (b == 7);
            sb.push_back(e);
            model_cnt[b] = '0;
        end
        chk("dump_valid_start", bus.out_valid, 1);
        chk("dump_busy_start", bus.busy, 1);
        chk("dump_ovf_start", bus.overflow, model_ovf);
        while (n < 8 && cyc < 64) begin
            bus.out_ready = stall ? (ph == 0 || ph == 3) : 1'b1;
            if (inject) begin
                bus.sample_valid = 1'b1;
                bus.sample_data  = 8'h60;
            end
            @(negedge clk);
            chk("out_valid", bus.out_valid, 1);
            if (inject) chk("ready_in_dump", bus.sample_ready, 0);
            if (abort_at == n) begin
                chk("abort_bin", bus.out_bin, sb[0].bin);
                #2 rst_n = 1'b0;
                #1;
                chk("abort_valid", bus.out_valid, 0);
                chk("abort_busy", bus.busy, 0);
                chk("abort_ready", bus.sample_ready, 1);
                chk("abort_data", bus.out_data, 0);
                chk("abort_bin0", bus.out_bin, 0);
                bus.out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk("abort_ready_rel", bus.sample_ready, 1);
                sb.delete();
                model_clear();
                return;
            end
            if (bus.out_ready) begin
                e = sb.pop_front();
                chk("word_bin", bus.out_bin, e.bin);
                chk("word_data", bus.out_data, e.data);
                chk("word_last", bus.out_last, e.last);
                n++;
            end else begin
                chk("stall_bin", bus.out_bin, sb[0].bin);
                chk("stall_data", bus.out_data, sb[0].data);
                chk("stall_last", bus.out_last, sb[0].last);
            end
            ph = (ph + 1) % 4;
            @(posedge clk); #1;
            cyc++;
        end
        bus.sample_valid = 1'b0;
        bus.out_ready    = 1'b0;
        if (n < 8) begin
            chk("dump_timeout", 32'(n), 8);
            sb.delete();
        end
        model_ovf = 1'b0;
        chk("end_ready", bus.sample_ready, 1);
        chk("end_busy", bus.busy, 0);
        chk("end_valid", bus.out_valid, 0);
        chk("end_ovf", bus.overflow, 0);
    endtask

    initial begin
        bus.sample_data  = '0;
        bus.sample_valid = 1'b0;
        bus.dump_req     = 1'b0;
        bus.out_ready    = 1'b0;
        model_clear();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        chk("rst_ready", bus.sample_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bin", bus.out_bin, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_ovf", bus.overflow, 0);

        // basic accumulate and dump
        repeat (3) send(8'hE0, 1'b0);
        send(8'h1F, 1'b0);
        do_dump(1'b1, 1'b0, 1'b0, -1);

        // clear-on-read
        do_dump(1'b1, 1'b0, 1'b0, -1);

        // counter overflow on bin 2
        repeat (17) send(8'h40, 1'b0);
        chk("ovf_before_dump", bus.overflow, 1);
        do_dump(1'b1, 1'b0, 1'b0, -1);

        // sample with dump_req in the same cycle, samples refused during dump
        send(8'h20, 1'b1);
        do_dump(1'b0, 1'b0, 1'b1, -1);

        // back-pressured readout; bin 3 must not include injected samples
        repeat (2) send(8'h60, 1'b0);
        send(8'hA0, 1'b0);
        do_dump(1'b1, 1'b1, 1'b0, -1);

        // reset in the middle of a dump, then counters must be empty
        repeat (2) send(8'hA0, 1'b0);
        send(8'hC0, 1'b0);
        do_dump(1'b1, 1'b0, 1'b0, 4);
        do_dump(1'b1, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hist_stream_engine.md
# hist_stream_engine

Parametrised histogram engine: accumulates incoming samples into 2^BIN_BITS counters indexed by the sample's top BIN_BITS bits, then streams all bins out over a valid/ready interface on request, clearing each bin as it is read. It sits behind the chip pin wrapper in place of the fixed-width histogram. It adds configurable width, depth and counter size, a back-pressured readout and a sticky overflow flag.

## Interface
- DATA_W, 16, sample width in bits
- BIN_BITS, 4, log2 of bin count; NUM_BINS = 2^BIN_BITS; constraint 1 <= BIN_BITS <= DATA_W
- CNT_W, 8, per-bin counter width

- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- sample_data  input  DATA_W  sample; bin = sample_data[DATA_W-1 -: BIN_BITS]
- sample_valid  input  1  sample present
- sample_ready  output  1  engine accepts samples (state ACCUM)
- dump_req  input  1  single-cycle request to start readout
- out_data  output  CNT_W  count of current readout bin
- out_bin  output  BIN_BITS  index of current readout bin
- out_valid  output  1  readout word valid
- out_last  output  1  current word is bin NUM_BINS-1
- out_ready  input  1  downstream accepts readout word
- busy  output  1  readout in progress (state DUMP)
- overflow  output  1  sticky: a counter increment exceeded 2^CNT_W-1 since last completed dump

## Operation
- States: ACCUM, DUMP. Reset state ACCUM.
- ACCUM: sample_ready=1; on sample_valid, counter[bin] increments on that edge. dump_req -> DUMP next cycle, rd_idx=0.
- Same-cycle sample_valid and dump_req in ACCUM: sample counted first, then DUMP.
- DUMP: sample_ready=0, busy=1, out_valid=1, out_bin=rd_idx, out_data=counter[rd_idx], out_last=(rd_idx==NUM_BINS-1). sample_valid ignored, no count. dump_req ignored.
- Handshake out_valid&out_ready: counter[rd_idx] cleared to 0, rd_idx increments. If out_last: rd_idx=0, overflow cleared, state -> ACCUM.
- Stall (out_ready=0): out_data, out_bin, out_last held stable; nothing changes.
- Overflow: increment of a counter at 2^CNT_W-1 sets overflow (behaviour of the counter itself per Configuration). Overflow on the same edge as the final handshake: set wins.
- No arithmetic other than +1 per counter; index arithmetic wraps modulo NUM_BINS.

## Timing
- Accumulate latency: count visible one cycle after the accepting edge. Back-to-back samples to the same bin every cycle count correctly (no read-modify-write hazard; counters are flops).
- dump_req edge -> out_valid high next cycle.
- Readout throughput one bin per cycle with out_ready held high; full dump = NUM_BINS cycles plus 1 cycle of request latency.
- Final handshake edge -> sample_ready=1 next cycle.
- Reset values: all counters 0, state ACCUM, sample_ready 1, out_valid 0, busy 0, out_bin 0, out_data 0, out_last 0, overflow 0.
- rst_n low mid-dump: immediate abort, all counters and flags cleared asynchronously, ACCUM after release.

## Configuration
- HIST_SATURATE_EN defined: counter at 2^CNT_W-1 stays at max on increment; overflow set.
- HIST_SATURATE_EN undefined: counter wraps to 0; overflow set.

## Test plan
(DATA_W=8, BIN_BITS=3, CNT_W=4)
- Reset, 3 samples 0xE0 then 1 sample 0x1F, dump with out_ready=1 -> 8 words, bin 7 = 3, bin 0 = 1, others 0, out_last only on bin 7, overflow 0.
- Dump again immediately -> all 8 words 0 (clear-on-read).
- 17 samples 0x40 then dump -> bin 2 = 15 with HIST_SATURATE_EN, 1 without; overflow=1 during dump, 0 after final handshake.
- Sample 0x20 with dump_req same cycle -> bin 1 = 1 in dump; samples driven during DUMP see sample_ready=0 and are not counted.
- out_ready toggled 1,0,0,1 during dump -> out_bin/out_data constant across stall cycles, no bin skipped or repeated.
- rst_n pulsed low while out_bin=4 -> out_valid 0 immediately, counters 0, sample_ready 1 after release.
